// File: rtl/serial_adder_n_pkg.sv
// Shared definitions for the serial adder.
//   sa_state_e : 2-bit FSM encoding (IDLE=0, RUN=1, DONE=2)
//   clog2      : ceiling log2, used to size the chunk counter
package serial_adder_n_pkg;

  typedef enum logic [1:0] {
    SA_IDLE = 2'd0,
    SA_RUN  = 2'd1,
    SA_DONE = 2'd2
  } sa_state_e;

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/serial_adder_n_chunk.sv
// adder_chunk: combinational ripple of CHUNK full-adder cells.
//   a, b : CHUNK-bit operand slices
//   ci   : carry in
//   s    : CHUNK-bit sum slice
//   co   : carry out of the top cell
module adder_chunk #(
  parameter int CHUNK = 1
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co
);

  logic [CHUNK:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign co = c[CHUNK];

endmodule

// File: rtl/serial_adder_n.sv
// serial_adder_n: multi-cycle adder, CHUNK bits per clock with a registered
// carry. sum/cout = a + b + cin (unsigned, WIDTH bits + carry-out).
//   clk, rst : clock, synchronous active-high reset
//   start    : request, honoured only in IDLE or DONE
//   a, b, cin: operands, latched when start is accepted
//   busy     : high while adding (RUN)
//   done     : one-cycle pulse when sum/cout have just been updated
//   sum, cout: last result, held until the next completion or reset
// WIDTH >= 2 and WIDTH % CHUNK == 0 are assumed.
module serial_adder_n
  import serial_adder_n_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = clog2(N) + 1;

  sa_state_e        state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr, part;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic [CHUNK-1:0] ch_s;
  logic             ch_co;
  logic [WIDTH-1:0] ch_ext, part_nxt;
  logic             last, accept;

  adder_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a  (a_sr[CHUNK-1:0]),
    .b  (b_sr[CHUNK-1:0]),
    .ci (carry),
    .s  (ch_s),
    .co (ch_co)
  );

  // Result bits enter from the MSB side so after N steps the low chunk
  // computed first has reached bit 0. Written as shifts so CHUNK==WIDTH
  // needs no special case.
  assign ch_ext   = WIDTH'(ch_s);
  assign part_nxt = (part >> CHUNK) | (ch_ext << (WIDTH - CHUNK));

  assign last   = (cnt == CW'(N - 1));
  assign accept = start && (state == SA_IDLE || state == SA_DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      SA_IDLE: if (start) state_nxt = SA_RUN;
      SA_RUN:  if (last)  state_nxt = SA_DONE;
      SA_DONE: state_nxt = start ? SA_RUN : SA_IDLE;
      default: state_nxt = SA_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SA_IDLE;
      a_sr  <= '0;
      b_sr  <= '0;
      part  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        a_sr  <= a;
        b_sr  <= b;
        carry <= cin;
        part  <= '0;
        cnt   <= '0;
      end else if (state == SA_RUN) begin
        a_sr  <= a_sr >> CHUNK;
        b_sr  <= b_sr >> CHUNK;
        carry <= ch_co;
        part  <= part_nxt;
        cnt   <= cnt + CW'(1);
        if (last) begin
          sum  <= part_nxt;
          cout <= ch_co;
        end
      end
    end
  end

  assign busy = (state == SA_RUN);
  assign done = (state == SA_DONE);

endmodule
